// File: rtl/adaptive_threshold_pkg.sv
// adaptive_threshold_pkg: shared widths and derived constants for the adaptive-threshold result path
package adaptive_threshold_pkg;
    localparam int DEFAULT_WIDTH_BITS = 8;
    localparam int DEFAULT_HEIGHT_BITS = 8;
    localparam int DEFAULT_NUM_LANES_BITS = 2;
    localparam int DEFAULT_FIFO_DEPTH_BITS = 2;
    localparam int DEFAULT_ENTRY_BITS = DEFAULT_WIDTH_BITS + DEFAULT_HEIGHT_BITS + 1;
    localparam int DEFAULT_FRAME_PIXELS = 1 << (DEFAULT_WIDTH_BITS + DEFAULT_HEIGHT_BITS);

    function automatic int entry_bits(input int width_bits, input int height_bits);
        return width_bits + height_bits + 1;
    endfunction
endpackage

// File: rtl/result_write_arbiter_if.sv
// result_write_arbiter_if: lane result inputs and the single frame-buffer pixel write port
interface result_write_arbiter_if
    import adaptive_threshold_pkg::*;
#(
    parameter int NUM_LANES   = 1 << DEFAULT_NUM_LANES_BITS,
    parameter int WIDTH_BITS  = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEFAULT_HEIGHT_BITS
);
    logic                                iClear;
    logic [NUM_LANES*WIDTH_BITS-1:0]     iCol;
    logic [NUM_LANES*HEIGHT_BITS-1:0]    iRow;
    logic [NUM_LANES-1:0]                iData;
    logic [NUM_LANES-1:0]                iWren;
    logic [WIDTH_BITS-1:0]               oX;
    logic [HEIGHT_BITS-1:0]              oY;
    logic [2:0]                          oR;
    logic [2:0]                          oG;
    logic [2:0]                          oB;
    logic                                oWren;
    logic [NUM_LANES-1:0]                oOverflow;
    logic [WIDTH_BITS+HEIGHT_BITS:0]     oWriteCount;
    logic                                oFrameDone;

    modport master (
        output iClear, iCol, iRow, iData, iWren,
        input  oX, oY, oR, oG, oB, oWren, oOverflow, oWriteCount, oFrameDone
    );

    modport slave (
        input  iClear, iCol, iRow, iData, iWren,
        output oX, oY, oR, oG, oB, oWren, oOverflow, oWriteCount, oFrameDone
    );
endinterface

// File: rtl/result_lane_fifo.sv
// result_lane_fifo: per-lane entry buffer; a push into a full buffer is kept when the head pops that cycle
module result_lane_fifo
    import adaptive_threshold_pkg::*;
#(
    parameter int ENTRY_BITS      = DEFAULT_ENTRY_BITS,
    parameter int FIFO_DEPTH_BITS = DEFAULT_FIFO_DEPTH_BITS
) (
    input  logic                  clock,
    input  logic                  not_reset,
    input  logic                  iClear,
    input  logic                  iPush,
    input  logic [ENTRY_BITS-1:0] iData,
    input  logic                  iPop,
    output logic [ENTRY_BITS-1:0] oData,
    output logic                  oEmpty,
    output logic                  oFull,
    output logic                  oOverflowPulse
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    logic [ENTRY_BITS-1:0]      mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
    logic                       push_ok, pop_ok;

    assign oData = mem_q[rd_ptr_q];

    always_comb begin
        oEmpty = count_q == '0;
        oFull = count_q == (FIFO_DEPTH_BITS+1)'(DEPTH);
        pop_ok = iPop && !oEmpty;
        push_ok = iPush && (!oFull || pop_ok);
        oOverflowPulse = iPush && !push_ok && !iClear;
        wr_ptr_d = iClear ? '0 : wr_ptr_q + FIFO_DEPTH_BITS'(push_ok);
        rd_ptr_d = iClear ? '0 : rd_ptr_q + FIFO_DEPTH_BITS'(pop_ok);
        count_d = iClear ? '0 : count_q + (FIFO_DEPTH_BITS+1)'(push_ok) - (FIFO_DEPTH_BITS+1)'(pop_ok);
    end

    always_ff @(posedge clock)
        if (push_ok && !iClear) mem_q[wr_ptr_q] <= iData;

    always_ff @(posedge clock or negedge not_reset)
        if (!not_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
endmodule

// File: rtl/result_write_arbiter.sv
// result_write_arbiter: buffers box_filter lane results, round-robin merges them onto one registered pixel write port
module result_write_arbiter
    import adaptive_threshold_pkg::*;
#(
    parameter int NUM_LANES_BITS  = DEFAULT_NUM_LANES_BITS,
    parameter int NUM_LANES       = 1 << NUM_LANES_BITS,
    parameter int WIDTH_BITS      = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS     = DEFAULT_HEIGHT_BITS,
    parameter int FIFO_DEPTH_BITS = DEFAULT_FIFO_DEPTH_BITS
) (
    input logic                    clock,
    input logic                    not_reset,
    result_write_arbiter_if.slave  bus
);
    localparam int LANE_ENTRY_BITS = entry_bits(WIDTH_BITS, HEIGHT_BITS);
    localparam int COUNT_BITS = WIDTH_BITS + HEIGHT_BITS + 1;
    localparam logic [COUNT_BITS-1:0] FRAME_COUNT = {1'b1, {(COUNT_BITS-1){1'b0}}};

    logic [LANE_ENTRY_BITS-1:0] head [NUM_LANES];
    logic [NUM_LANES-1:0]       empty, full_unused, pop, ovf_pulse;
    logic [NUM_LANES_BITS-1:0]  ptr_q, ptr_d, gnt, idx;
    logic                       gnt_v;
    logic [WIDTH_BITS-1:0]      x_q, x_d;
    logic [HEIGHT_BITS-1:0]     y_q, y_d;
    logic                       data_q, data_d, wren_q, wren_d, done_q, done_d;
    logic [NUM_LANES-1:0]       ovf_q, ovf_d;
    logic [COUNT_BITS-1:0]      count_q, count_d;

    genvar i;
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
        result_lane_fifo #(
            .ENTRY_BITS      (LANE_ENTRY_BITS),
            .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clock          (clock),
            .not_reset      (not_reset),
            .iClear         (bus.iClear),
            .iPush          (bus.iWren[i]),
            .iData          ({bus.iCol[i*WIDTH_BITS +: WIDTH_BITS], bus.iRow[i*HEIGHT_BITS +: HEIGHT_BITS], bus.iData[i]}),
            .iPop           (pop[i]),
            .oData          (head[i]),
            .oEmpty         (empty[i]),
            .oFull          (full_unused[i]),
            .oOverflowPulse (ovf_pulse[i])
        );
    end

    // scan from the farthest offset down so the lane nearest ptr wins
    always_comb begin
        gnt_v = 1'b0;
        gnt = ptr_q;
        idx = ptr_q;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = ptr_q + NUM_LANES_BITS'(k);
            if (!empty[idx]) begin
                gnt_v = 1'b1;
                gnt = idx;
            end
        end
        pop = gnt_v ? NUM_LANES'(1) << gnt : '0;
        ptr_d = bus.iClear ? '0 : gnt_v ? gnt + NUM_LANES_BITS'(1) : ptr_q;
    end

    always_comb begin
        {x_d, y_d, data_d} = gnt_v ? head[gnt] : {x_q, y_q, data_q};
        wren_d = gnt_v;
        ovf_d = ovf_q | ovf_pulse;
        count_d = (gnt_v && count_q != '1) ? count_q + COUNT_BITS'(1) : count_q;
        done_d = done_q || count_d == FRAME_COUNT;
        if (bus.iClear) begin
            {x_d, y_d, data_d} = '0;
            wren_d = 1'b0;
            ovf_d = '0;
            count_d = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge not_reset)
        if (!not_reset) begin
            ptr_q <= '0;
            x_q <= '0;
            y_q <= '0;
            data_q <= 1'b0;
            wren_q <= 1'b0;
            ovf_q <= '0;
            count_q <= '0;
            done_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            x_q <= x_d;
            y_q <= y_d;
            data_q <= data_d;
            wren_q <= wren_d;
            ovf_q <= ovf_d;
            count_q <= count_d;
            done_q <= done_d;
        end

    assign bus.oX = x_q;
    assign bus.oY = y_q;
    assign bus.oR = {3{data_q}};
    assign bus.oG = {3{data_q}};
    assign bus.oB = {3{data_q}};
    assign bus.oWren = wren_q;
    assign bus.oOverflow = ovf_q;
    assign bus.oWriteCount = count_q;
    assign bus.oFrameDone = done_q;
endmodule

// File: tb/tb_result_write_arbiter.sv
// tb_result_write_arbiter: per-lane scoreboard queues plus directed checks for the result write arbiter
module tb_result_write_arbiter;
    import adaptive_threshold_pkg::*;

    localparam int NL = 4;
    localparam int DEPTH = 4;
    localparam int CNT_MAX = (1 << 17) - 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       d;
    } ent_t;

    logic clock = 1'b0;
    logic not_reset = 1'b0;
    int checks = 0;
    int errors = 0;

    result_write_arbiter_if bus ();
    result_write_arbiter dut (.clock(clock), .not_reset(not_reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    ent_t       lane_q [NL][$];
    ent_t       m_out = '0;
    logic       m_wren = 1'b0;
    logic [3:0] m_ovf = '0;
    logic       m_done = 1'b0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    int         m_g;

    task automatic model_clear();
        for (int l = 0; l < NL; l++) lane_q[l].delete();
        m_out = '0;
        m_wren = 1'b0;
        m_ovf = '0;
        m_done = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // pop before push so a full lane that is granted still accepts the new entry
    always @(posedge clock or negedge not_reset) begin
        if (!not_reset) model_clear();
        else begin
            if (bus.iClear) model_clear();
            else begin
                m_g = -1;
                for (int k = 0; k < NL; k++)
                    if (m_g < 0 && lane_q[(m_ptr + k) % NL].size() > 0) m_g = (m_ptr + k) % NL;
                m_wren = m_g >= 0;
                if (m_g >= 0) begin
                    m_out = lane_q[m_g].pop_front();
                    m_ptr = (m_g + 1) % NL;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (m_cnt == DEFAULT_FRAME_PIXELS) m_done = 1'b1;
                end
                for (int l = 0; l < NL; l++)
                    if (bus.iWren[l]) begin
                        if (lane_q[l].size() < DEPTH)
                            lane_q[l].push_back(ent_t'({bus.iCol[l*8 +: 8], bus.iRow[l*8 +: 8], bus.iData[l]}));
                        else
                            m_ovf[l] = 1'b1;
                    end
            end
            #1;
            check("sb_wren", bus.oWren, m_wren);
            check("sb_x", bus.oX, m_out.x);
            check("sb_y", bus.oY, m_out.y);
            check("sb_rgb", {bus.oR, bus.oG, bus.oB}, {9{m_out.d}});
            check("sb_ovf", bus.oOverflow, m_ovf);
            check("sb_count", bus.oWriteCount, m_cnt);
            check("sb_done", bus.oFrameDone, m_done);
        end
    end

    task automatic push(input logic [3:0] w, input logic [3:0] d, input logic [31:0] c, input logic [31:0] r);
        bus.iWren = w;
        bus.iData = d;
        bus.iCol = c;
        bus.iRow = r;
        @(posedge clock);
        #2;
        bus.iWren = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic clear();
        bus.iClear = 1'b1;
        @(posedge clock);
        #2;
        bus.iClear = 1'b0;
        bus.iWren = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wren"}, bus.oWren, 0);
        check({tag, "_x"}, bus.oX, 0);
        check({tag, "_y"}, bus.oY, 0);
        check({tag, "_ovf"}, bus.oOverflow, 0);
        check({tag, "_count"}, bus.oWriteCount, 0);
        check({tag, "_done"}, bus.oFrameDone, 0);
    endtask

    initial begin
        bus.iClear = 1'b0;
        bus.iWren = '0;
        bus.iData = '0;
        bus.iCol = '0;
        bus.iRow = '0;
        idle(2);
        check_zero("reset");
        not_reset = 1'b1;
        idle(1);

        push(4'b0100, 4'b0100, 32'h0012_0000, 32'h0034_0000);
        check("single_latency", bus.oWren, 0);
        idle(1);
        check("single_wren", bus.oWren, 1);
        check("single_x", bus.oX, 'h12);
        check("single_y", bus.oY, 'h34);
        check("single_r", bus.oR, 7);
        check("single_g", bus.oG, 7);
        check("single_b", bus.oB, 7);
        check("single_count", bus.oWriteCount, 1);
        idle(1);
        check("single_off", bus.oWren, 0);
        check("single_hold", bus.oX, 'h12);

        clear();
        check_zero("clear1");
        push(4'hF, 4'b1010, 32'h0302_0100, 32'h4342_4140);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("sim_wren", bus.oWren, 1);
            check("sim_x", bus.oX, i);
            check("sim_y", bus.oY, 'h40 + i);
            check("sim_data", bus.oR, (i % 2) != 0 ? 7 : 0);
        end
        idle(1);
        check("sim_end", bus.oWren, 0);
        check("sim_ovf", bus.oOverflow, 0);

        clear();
        for (int i = 0; i < 20; i++) begin
            push(4'b0011, 4'b0001, {16'h0, 8'(i), 8'(i)}, 32'h0000_0100);
            if (i > 0) check("fair_lane", bus.oY, (i - 1) % 2);
        end
        check("fair_ovf", bus.oOverflow, 4'b0011);
        idle(12);
        check("fair_drained", bus.oWren, 0);
        check("fair_ovf_sticky", bus.oOverflow, 4'b0011);

        clear();
        for (int i = 0; i < 5; i++)
            push(i < 4 ? 4'hF : 4'h8, 4'h8, {4{8'(i)}}, {4{8'(i + 8)}});
        check("fullpop_ovf", bus.oOverflow, 0);
        idle(20);
        check("fullpop_count", bus.oWriteCount, 17);

        clear();
        for (int i = 0; i < DEFAULT_FRAME_PIXELS; i++)
            push(4'(1 << (i % 4)), 4'($urandom), {4{8'(i)}}, {4{8'(i >> 8)}});
        check("pre_done_count", bus.oWriteCount, DEFAULT_FRAME_PIXELS - 1);
        check("pre_done", bus.oFrameDone, 0);
        idle(1);
        check("done_count", bus.oWriteCount, DEFAULT_FRAME_PIXELS);
        check("done", bus.oFrameDone, 1);
        check("done_last_x", bus.oX, 'hFF);
        push(4'h1, 4'h1, 32'h0000_00AA, 32'h0000_0055);
        idle(1);
        check("post_done_wren", bus.oWren, 1);
        check("post_done_count", bus.oWriteCount, DEFAULT_FRAME_PIXELS + 1);
        check("post_done", bus.oFrameDone, 1);

        for (int i = 0; i < 4; i++) push(4'hF, 4'hF, $urandom, $urandom);
        #1;
        not_reset = 1'b0;
        #1;
        check_zero("async_rst");
        idle(2);
        not_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("rst_no_wren", bus.oWren, 0);
        end

        for (int i = 0; i < 4; i++) push(4'hF, 4'hF, $urandom, $urandom);
        bus.iWren = 4'hF;
        clear();
        check_zero("sync_clear");
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("clr_no_wren", bus.oWren, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
